// File: rtl/collatz_inverse_search.sv
// Collatz inverse search: finds the smallest N in [1, N_MAX] whose Collatz
// step count equals K. The search runs one Collatz operation per cycle. A
// candidate is dropped as soon as its step count passes K, or when 3n+1 does
// not fit in W bits.
module collatz_inverse_search #(
  parameter int unsigned W     = 16,
  parameter int unsigned N_MAX = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   k_in,
  output logic [W-1:0] n_out,
  output logic         busy,
  output logic         done,
  output logic         fail
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStep, StCheck, StNext, StDone, StFail
  } state_e;

  localparam logic [W-1:0] NMax  = W'(N_MAX);
  localparam logic [W-1:0] One   = W'(1);
  // Largest trajectory value that still fits in W bits.
  localparam logic [W+1:0] Limit = {2'b00, {W{1'b1}}};

  state_e         state_q, state_d;
  logic [7:0]     k_q, k_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   cand_q, cand_d;
  logic [W-1:0]   n_q, n_d;
  logic [W-1:0]   n_out_q, n_out_d;
  logic [W+1:0]   triple;
  logic [7:0]     cnt_inc;

  // 3n+1 is formed as n + 2n + 1 at W+2 bits, so an overflow is visible.
  assign triple  = {2'b00, n_q} + {1'b0, n_q, 1'b0} + {{(W+1){1'b0}}, 1'b1};
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Next-state logic and datapath updates for the search FSM.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    n_d     = n_q;
    n_out_d = n_out_q;
    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          k_d     = k_in;
          cand_d  = One;
          n_out_d = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        n_d     = cand_q;
        cnt_d   = 8'd0;
        state_d = StStep;
      end
      StStep: begin
        if (n_q == One) begin
          state_d = StCheck;
        end else if (cnt_q == k_q) begin
          // The count has already reached K and n is not 1, so this candidate cannot match.
          state_d = StNext;
        end else if (n_q[0]) begin
          if (triple > Limit) begin
            state_d = StNext;
          end else begin
            n_d   = triple[W-1:0];
            cnt_d = cnt_inc;
          end
        end else begin
          n_d   = n_q >> 1;
          cnt_d = cnt_inc;
        end
      end
      StCheck: begin
        if (cnt_q == k_q) begin
          n_out_d = cand_q;
          state_d = StDone;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (cand_q == NMax) begin
          n_out_d = '0;
          state_d = StFail;
        end else begin
          cand_d  = cand_q + One;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      cand_q  <= '0;
      n_q     <= '0;
      n_out_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      n_q     <= n_d;
      n_out_q <= n_out_d;
    end
  end

  // Status outputs are decoded directly from the state.
  always_comb begin
    busy  = (state_q == StLoad) || (state_q == StStep) ||
            (state_q == StCheck) || (state_q == StNext);
    done  = (state_q == StDone);
    fail  = (state_q == StFail);
    n_out = n_out_q;
  end

endmodule
